// File: rtl/led_adder_pkg.sv
// Shared types and elaboration helpers for the LED adder compute core.
package led_adder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADD     = 2'd1,
        DISPLAY = 2'd2
    } state_e;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int CHUNK_W_DEF     = 8;
    localparam int LED_WIDTH_DEF   = 4;
    localparam int HOLD_CYCLES_DEF = 25000000;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit cfg_ok(input int dw, input int cw, input int lw, input int hold);
        return (cw > 0) && (lw > 0) && (dw >= cw) && (dw >= lw) &&
               ((dw % cw) == 0) && ((dw % lw) == 0) && (hold >= 1);
    endfunction

endpackage

// File: rtl/led_seg_sequencer.sv
// Steps a captured result onto the LEDs one segment at a time, holding each
// segment for HOLD_CYCLES clocks, then parks the LEDs on segment 0.
module led_seg_sequencer
    import led_adder_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int LED_WIDTH   = LED_WIDTH_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  go,
    input  logic [DATA_WIDTH-1:0] result,
    output logic [LED_WIDTH-1:0]  leds,
    output logic                  seq_done
);

    localparam int N_SEG = DATA_WIDTH / LED_WIDTH;
    localparam int S_W   = cnt_w(N_SEG);
    localparam int H_W   = cnt_w(HOLD_CYCLES);

    localparam logic [S_W-1:0] S_LAST = S_W'(N_SEG - 1);
    localparam logic [H_W-1:0] H_LAST = H_W'(HOLD_CYCLES - 1);

    logic                  active_q;
    logic [S_W-1:0]        s_q;
    logic [S_W-1:0]        s_nxt;
    logic [H_W-1:0]        h_q;
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [LED_WIDTH-1:0]  leds_q;

    assign s_nxt    = s_q + 1'b1;
    assign seq_done = active_q && (s_q == S_LAST) && (h_q == H_LAST);
    assign leds     = leds_q;

    // go carries the sum being committed this cycle, so segment 0 shows
    // from the first DISPLAY cycle without waiting on the result register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            active_q <= 1'b0;
            s_q      <= '0;
            h_q      <= '0;
            shadow_q <= '0;
            leds_q   <= '0;
        end else if (go) begin
            active_q <= 1'b1;
            s_q      <= '0;
            h_q      <= '0;
            shadow_q <= result;
            leds_q   <= result[LED_WIDTH-1:0];
        end else if (active_q) begin
            if (h_q == H_LAST) begin
                h_q <= '0;
                if (s_q == S_LAST) begin
                    active_q <= 1'b0;
                    s_q      <= '0;
                    leds_q   <= shadow_q[LED_WIDTH-1:0];
                end else begin
                    s_q    <= s_nxt;
                    leds_q <= shadow_q[int'(s_nxt)*LED_WIDTH +: LED_WIDTH];
                end
            end else begin
                h_q <= h_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_adder_core.sv
// Chunked multi-cycle adder behind the LEDAdderIP register file, with
// optional hand-off of the sum to the LED segment sequencer.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; result/carry/leds hold last values
//   ADD     | one CHUNK_W slice of the latched operands added per cycle
//   DISPLAY | sequencer walking the result across the LEDs; still busy
module led_adder_core
    import led_adder_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int CHUNK_W     = CHUNK_W_DEF,
    parameter int LED_WIDTH   = LED_WIDTH_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  start,
    input  logic                  disp_en,
    input  logic                  clr_status,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  busy,
    output logic                  done,
    output logic                  err_busy,
    output logic [LED_WIDTH-1:0]  leds
);

    localparam int N_CHUNK = DATA_WIDTH / CHUNK_W;
    localparam int K_W     = cnt_w(N_CHUNK);

    localparam logic [K_W-1:0] K_LAST = K_W'(N_CHUNK - 1);

    if (!cfg_ok(DATA_WIDTH, CHUNK_W, LED_WIDTH, HOLD_CYCLES)) begin : g_cfg_check
        $error("led_adder_core: DATA_WIDTH must be a multiple of CHUNK_W and LED_WIDTH, HOLD_CYCLES >= 1");
    end

    state_e                state_q, state_d;

    logic [DATA_WIDTH-1:0] a_q, b_q, acc_q, acc_nxt;
    logic                  c_q;
    logic [K_W-1:0]        k_q;
    logic [CHUNK_W-1:0]    chunk_a, chunk_b;
    logic [CHUNK_W:0]      chunk_sum;

    logic [DATA_WIDTH-1:0] result_q;
    logic                  carry_q, busy_q, done_q, err_q;

    logic                  accept, reject, last_chunk, seq_go, seq_done;

    // FSM: state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state and control strobes. A start landing on the done
    // cycle is still treated as busy even though state is already IDLE.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        reject     = 1'b0;
        last_chunk = 1'b0;
        seq_go     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (done_q) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ADD;
                    end
                end
            end
            ADD: begin
                reject = start;
                if (k_q == K_LAST) begin
                    last_chunk = 1'b1;
                    seq_go     = disp_en;
                    state_d    = disp_en ? DISPLAY : IDLE;
                end
            end
            DISPLAY: begin
                reject = start;
                if (seq_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        chunk_a   = a_q[int'(k_q)*CHUNK_W +: CHUNK_W];
        chunk_b   = b_q[int'(k_q)*CHUNK_W +: CHUNK_W];
        chunk_sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK_W{1'b0}}, c_q};
        acc_nxt   = acc_q;
        acc_nxt[int'(k_q)*CHUNK_W +: CHUNK_W] = chunk_sum[CHUNK_W-1:0];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            k_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= last_chunk;
            busy_q <= (state_d != IDLE);

            if (accept) begin
                a_q   <= op_a;
                b_q   <= op_b;
                acc_q <= '0;
                c_q   <= 1'b0;
                k_q   <= '0;
            end else if (state_q == ADD) begin
                acc_q <= acc_nxt;
                c_q   <= chunk_sum[CHUNK_W];
                k_q   <= k_q + 1'b1;
            end

            if (last_chunk) begin
                result_q <= acc_nxt;
                carry_q  <= chunk_sum[CHUNK_W];
            end

            // Setting wins over clearing when both land together.
            if (reject)          err_q <= 1'b1;
            else if (clr_status) err_q <= 1'b0;
        end
    end

    led_seg_sequencer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LED_WIDTH  (LED_WIDTH),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_seq (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .go      (seq_go),
        .result  (acc_nxt),
        .leds    (leds),
        .seq_done(seq_done)
    );

    assign result   = result_q;
    assign carry    = carry_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_busy = err_q;

endmodule
